// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the FSM state encoding, default sizing and the retired-count helper.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fetch_state_t;

    localparam int DEF_D = 12;
    localparam int DEF_B = 8;
    localparam int CNT_W = 16;

    // Retired-instruction counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Program-counter sequencer: launches a run from address 0, follows branches,
// honours stalls, and stops on halt while counting retired instructions.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int D = DEF_D,
    parameter int B = DEF_B
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stall,
    input  logic                 halt_req,
    input  logic                 branch_en,
    input  logic [$clog2(B)-1:0] branch_idx,
    input  logic [D-1:0]         branch_table [B],
    output logic [D-1:0]         prog_ctr,
    output logic                 fetch_valid,
    output logic                 done,
    output logic [CNT_W-1:0]     instr_count
);

    fetch_state_t     state_reg, state_next;
    logic [D-1:0]     pc_reg, pc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            pc_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE, DONE: begin
                // A stall alongside start is honoured from the first RUN cycle.
                if (start) begin
                    state_next = RUN;
                    pc_next    = '0;
                    cnt_next   = '0;
                end
            end
            RUN: begin
                if (!stall) begin
                    cnt_next = sat_inc(cnt_reg);
                    if (halt_req) begin
                        state_next = DONE;
                    end else if (branch_en) begin
                        pc_next = branch_table[branch_idx];
                    end else begin
                        pc_next = pc_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                pc_next    = '0;
                cnt_next   = '0;
            end
        endcase
    end

    assign prog_ctr    = pc_reg;
    assign instr_count = cnt_reg;
    assign done        = (state_reg == DONE);
    assign fetch_valid = (state_reg == RUN) && !stall;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios plus randomized traffic
// compared every cycle against a behavioural run/stop model.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    localparam int D = 12;
    localparam int B = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic stall = 1'b0;
    logic halt_req = 1'b0;
    logic branch_en = 1'b0;
    logic [2:0] branch_idx = 3'd0;
    logic [D-1:0] tbl [B];
    logic [D-1:0] prog_ctr;
    logic fetch_valid;
    logic done;
    logic [15:0] instr_count;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Model: 0 = idle, 1 = running, 2 = finished.
    int m_st = 0;
    int m_pc = 0;
    int m_cnt = 0;

    fetch_ctrl #(.D(D), .B(B)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .stall(stall),
        .halt_req(halt_req),
        .branch_en(branch_en),
        .branch_idx(branch_idx),
        .branch_table(tbl),
        .prog_ctr(prog_ctr),
        .fetch_valid(fetch_valid),
        .done(done),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st  <= 0;
            m_pc  <= 0;
            m_cnt <= 0;
        end else if (m_st == 1) begin
            if (!stall) begin
                m_cnt <= (m_cnt >= 65535) ? 65535 : m_cnt + 1;
                if (halt_req)
                    m_st <= 2;
                else if (branch_en)
                    m_pc <= int'(tbl[branch_idx]);
                else
                    m_pc <= (m_pc + 1) % (1 << D);
            end
        end else if (start) begin
            m_st  <= 1;
            m_pc  <= 0;
            m_cnt <= 0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic dchk(input string name, input int act, input int exp);
        chk(name, act, exp);
        if (act == exp)
            $display("check %s actual=%0d required=%0d ok", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("model_pc", int'(prog_ctr), m_pc);
            chk("model_cnt", int'(instr_count), m_cnt);
            chk("model_done", int'(done), int'(m_st == 2));
            chk("model_fv", int'(fetch_valid), int'((m_st == 1) && !stall));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch();
        start = 1'b0; stall = 1'b0; halt_req = 1'b0; branch_en = 1'b0;
        reset = 1'b1;
        step();
        step();
        cmp_en = 1'b1;
        @(negedge clk);
        dchk("reset_pc", int'(prog_ctr), 0);
        dchk("reset_fv", int'(fetch_valid), 0);
        dchk("reset_done", int'(done), 0);
        dchk("reset_cnt", int'(instr_count), 0);
        step();
        reset = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        foreach (tbl[i]) tbl[i] = '0;

        // Straight-line run from address 0
        launch();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            dchk("seq_pc", int'(prog_ctr), k);
            dchk("seq_fv", int'(fetch_valid), 1);
            step();
        end
        @(negedge clk);
        dchk("seq_cnt", int'(instr_count), 5);

        // Branch through table entry 3 at PC 2
        launch();
        step();
        step();
        tbl[3] = 12'h040; branch_idx = 3'd3; branch_en = 1'b1;
        @(negedge clk);
        dchk("br_at_pc", int'(prog_ctr), 2);
        step();
        branch_en = 1'b0;
        @(negedge clk);
        dchk("br_target", int'(prog_ctr), 12'h040);

        // Stall outranks a pending branch
        launch();
        repeat (7) step();
        stall = 1'b1; branch_en = 1'b1; branch_idx = 3'd3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            dchk("stall_pc", int'(prog_ctr), 7);
            dchk("stall_fv", int'(fetch_valid), 0);
            dchk("stall_cnt", int'(instr_count), 7);
            step();
        end
        stall = 1'b0; branch_en = 1'b0;
        step();
        @(negedge clk);
        dchk("post_stall_pc", int'(prog_ctr), 8);
        dchk("post_stall_cnt", int'(instr_count), 8);

        // Halt outranks branch, then restart from DONE
        step();
        halt_req = 1'b1; branch_en = 1'b1;
        step();
        halt_req = 1'b0; branch_en = 1'b0;
        @(negedge clk);
        dchk("halt_done", int'(done), 1);
        dchk("halt_pc", int'(prog_ctr), 9);
        dchk("halt_fv", int'(fetch_valid), 0);
        dchk("halt_cnt", int'(instr_count), 10);
        step();
        @(negedge clk);
        dchk("done_hold", int'(done), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        @(negedge clk);
        dchk("restart_pc", int'(prog_ctr), 0);
        dchk("restart_cnt", int'(instr_count), 0);
        dchk("restart_done", int'(done), 0);

        // Branch to the top address, then wrap on increment
        tbl[5] = 12'hFFF; branch_idx = 3'd5; branch_en = 1'b1;
        step();
        branch_en = 1'b0;
        @(negedge clk);
        dchk("top_pc", int'(prog_ctr), 12'hFFF);
        step();
        @(negedge clk);
        dchk("wrap_pc", int'(prog_ctr), 0);
        dchk("wrap_fv", int'(fetch_valid), 1);
        dchk("wrap_done", int'(done), 0);

        // Asynchronous reset in the middle of a run
        launch();
        repeat (20) step();
        @(negedge clk);
        dchk("pre_abort_pc", int'(prog_ctr), 20);
        step();
        #1 reset = 1'b1;
        #1;
        dchk("abort_pc", int'(prog_ctr), 0);
        dchk("abort_fv", int'(fetch_valid), 0);
        dchk("abort_done", int'(done), 0);
        step();
        reset = 1'b0;
        repeat (3) step();
        @(negedge clk);
        dchk("idle_after_pc", int'(prog_ctr), 0);
        dchk("idle_after_done", int'(done), 0);
        dchk("idle_after_fv", int'(fetch_valid), 0);

        // Randomized traffic checked by the model every cycle
        launch();
        foreach (tbl[i]) tbl[i] = D'($urandom_range(0, (1 << D) - 1));
        for (int n = 0; n < 4000; n++) begin
            reset      = ($urandom_range(0, 249) == 0);
            start      = ($urandom_range(0, 15) == 0);
            stall      = ($urandom_range(0, 4) == 0);
            halt_req   = ($urandom_range(0, 39) == 0);
            branch_en  = ($urandom_range(0, 3) == 0);
            branch_idx = 3'($urandom_range(0, B - 1));
            if ($urandom_range(0, 31) == 0)
                tbl[$urandom_range(0, B - 1)] = D'($urandom_range(0, (1 << D) - 1));
            step();
        end
        reset = 1'b0; start = 1'b0; stall = 1'b0; halt_req = 1'b0; branch_en = 1'b0;
        step();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
